idex_stage: RTL and testbench

- Decode-to-execute pipeline stage sitting directly downstream of the decode controller in the 5-stage RV32I pipeline.
- Registers the controller's decode-stage control bundle together with the decode-stage datapath operands into execute-stage copies.
- Contains load-use hazard detection and branch/jump flush control that drive the fetch and decode stall/flush lines.
- Keeps saturating counters of inserted bubbles and flushes for performance debug.

---
 rtl/idex_stage.sv | 113 +++++++++++
 tb/tb_idex_stage.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/idex_stage.sv
// rtl/idex_stage.sv - ID/EX pipeline register with load-use stall, branch flush and perf counters
module idex_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            RegWriteD,
  input  logic            MemWriteD,
  input  logic            JumpD,
  input  logic            BranchD,
  input  logic            ALUSrcD,
  input  logic [1:0]      ResultSrcD,
  input  logic [4:0]      ALUControlD,
  input  logic [2:0]      mem_modeD,
  input  logic [XLEN-1:0] RD1D,
  input  logic [XLEN-1:0] RD2D,
  input  logic [XLEN-1:0] PCD,
  input  logic [XLEN-1:0] ImmExtD,
  input  logic [XLEN-1:0] PCPlus4D,
  input  logic [4:0]      Rs1D,
  input  logic [4:0]      Rs2D,
  input  logic [4:0]      RdD,
  input  logic            PCSrcE,
  output logic            RegWriteE,
  output logic            MemWriteE,
  output logic            JumpE,
  output logic            BranchE,
  output logic            ALUSrcE,
  output logic [1:0]      ResultSrcE,
  output logic [4:0]      ALUControlE,
  output logic [2:0]      mem_modeE,
  output logic [XLEN-1:0] RD1E,
  output logic [XLEN-1:0] RD2E,
  output logic [XLEN-1:0] PCE,
  output logic [XLEN-1:0] ImmExtE,
  output logic [XLEN-1:0] PCPlus4E,
  output logic [4:0]      Rs1E,
  output logic [4:0]      Rs2E,
  output logic [4:0]      RdE,
  output logic            StallF,
  output logic            StallD,
  output logic            FlushD,
  output logic            FlushE,
  output logic [CNT_W-1:0] bubble_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic load_e;
  logic lw_stall;

  // A taken branch/jump in E overrides the stall so the flush always wins.
  assign load_e   = (ResultSrcE == 2'b01);
  assign lw_stall = load_e & (RdE != 5'd0) & ((RdE == Rs1D) | (RdE == Rs2D)) & ~PCSrcE;

  assign StallF = lw_stall;
  assign StallD = lw_stall;
  assign FlushD = PCSrcE;
  assign FlushE = lw_stall | PCSrcE;

  // No hold path: a stall is a bubble here while F/D hold their contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || FlushE) begin
      RegWriteE   <= 1'b0;
      MemWriteE   <= 1'b0;
      JumpE       <= 1'b0;
      BranchE     <= 1'b0;
      ALUSrcE     <= 1'b0;
      ResultSrcE  <= 2'b00;
      ALUControlE <= 5'd0;
      mem_modeE   <= 3'd0;
      RD1E        <= '0;
      RD2E        <= '0;
      PCE         <= '0;
      ImmExtE     <= '0;
      PCPlus4E    <= '0;
      Rs1E        <= 5'd0;
      Rs2E        <= 5'd0;
      RdE         <= 5'd0;
    end else begin
      RegWriteE   <= RegWriteD;
      MemWriteE   <= MemWriteD;
      JumpE       <= JumpD;
      BranchE     <= BranchD;
      ALUSrcE     <= ALUSrcD;
      ResultSrcE  <= ResultSrcD;
      ALUControlE <= ALUControlD;
      mem_modeE   <= mem_modeD;
      RD1E        <= RD1D;
      RD2E        <= RD2D;
      PCE         <= PCD;
      ImmExtE     <= ImmExtD;
      PCPlus4E    <= PCPlus4D;
      Rs1E        <= Rs1D;
      Rs2E        <= Rs2D;
      RdE         <= RdD;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_cnt <= '0;
      flush_cnt  <= '0;
    end else begin
      if (lw_stall && (bubble_cnt != CNT_MAX)) bubble_cnt <= bubble_cnt + CNT_ONE;
      if (PCSrcE && (flush_cnt != CNT_MAX))    flush_cnt  <= flush_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_idex_stage.sv
// tb/tb_idex_stage.sv - directed table-driven bench for idex_stage
module tb_idex_stage;

  localparam int XLEN  = 32;
  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD;
  logic [1:0] ResultSrcD;
  logic [4:0] ALUControlD;
  logic [2:0] mem_modeD;
  logic [XLEN-1:0] RD1D, RD2D, PCD, ImmExtD, PCPlus4D;
  logic [4:0] Rs1D, Rs2D, RdD;
  logic PCSrcE;
  logic RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE;
  logic [1:0] ResultSrcE;
  logic [4:0] ALUControlE;
  logic [2:0] mem_modeE;
  logic [XLEN-1:0] RD1E, RD2E, PCE, ImmExtE, PCPlus4E;
  logic [4:0] Rs1E, Rs2E, RdE;
  logic StallF, StallD, FlushD, FlushE;
  logic [CNT_W-1:0] bubble_cnt, flush_cnt;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  idex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .JumpD(JumpD), .BranchD(BranchD),
    .ALUSrcD(ALUSrcD), .ResultSrcD(ResultSrcD), .ALUControlD(ALUControlD), .mem_modeD(mem_modeD),
    .RD1D(RD1D), .RD2D(RD2D), .PCD(PCD), .ImmExtD(ImmExtD), .PCPlus4D(PCPlus4D),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .PCSrcE(PCSrcE),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .JumpE(JumpE), .BranchE(BranchE),
    .ALUSrcE(ALUSrcE), .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE), .mem_modeE(mem_modeE),
    .RD1E(RD1E), .RD2E(RD2E), .PCE(PCE), .ImmExtE(ImmExtE), .PCPlus4E(PCPlus4E),
    .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
    .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
  );

  logic [189:0] e_bus;
  logic [189:0] d_bus;
  assign e_bus = {RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ResultSrcE, ALUControlE, mem_modeE,
                  RD1E, RD2E, PCE, ImmExtE, PCPlus4E, Rs1E, Rs2E, RdE};
  assign d_bus = {RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD, ResultSrcD, ALUControlD, mem_modeD,
                  RD1D, RD2D, PCD, ImmExtD, PCPlus4D, Rs1D, Rs2D, RdD};

  typedef struct {
    logic        rw;
    logic [1:0]  rs;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] rd1;
    logic        pc;
    logic        ex_stall;
    logic        ex_flushe;
    logic        ex_rw;
    logic [4:0]  ex_rd;
    logic [31:0] ex_rd1;
    logic [3:0]  ex_bub;
    logic [3:0]  ex_fl;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input logic [189:0] act, input logic [189:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_d();
    RegWriteD = 0; MemWriteD = 0; JumpD = 0; BranchD = 0; ALUSrcD = 0;
    ResultSrcD = 2'b00; ALUControlD = 5'd0; mem_modeD = 3'd0;
    RD1D = '0; RD2D = '0; PCD = '0; ImmExtD = '0; PCPlus4D = '0;
    Rs1D = 5'd0; Rs2D = 5'd0; RdD = 5'd0; PCSrcE = 0;
  endtask

  int stalls_seen;

  initial begin
    //            rw rs     rs1 rs2 rd  rd1    pc  stl flE rwE rdE rd1E   bub fl
    vecs[0]  = '{1, 2'b00, 1,  2,  5,  32'h11, 0,  0,  0,  1,  5,  32'h11, 0,  0};
    vecs[1]  = '{1, 2'b01, 5,  0,  7,  32'h20, 0,  0,  0,  1,  7,  32'h20, 0,  0};
    vecs[2]  = '{1, 2'b00, 7,  3,  8,  32'h30, 0,  1,  1,  0,  0,  32'h0,  1,  0};
    vecs[3]  = '{1, 2'b00, 7,  3,  8,  32'h30, 0,  0,  0,  1,  8,  32'h30, 1,  0};
    vecs[4]  = '{1, 2'b01, 0,  0,  0,  32'h40, 0,  0,  0,  1,  0,  32'h40, 1,  0};
    vecs[5]  = '{1, 2'b00, 0,  0,  9,  32'h50, 0,  0,  0,  1,  9,  32'h50, 1,  0};
    vecs[6]  = '{1, 2'b00, 9,  0,  10, 32'h60, 1,  0,  1,  0,  0,  32'h0,  1,  1};
    vecs[7]  = '{1, 2'b01, 0,  0,  12, 32'h70, 0,  0,  0,  1,  12, 32'h70, 1,  1};
    vecs[8]  = '{1, 2'b00, 0,  12, 13, 32'h80, 1,  0,  1,  0,  0,  32'h0,  1,  2};
    vecs[9]  = '{1, 2'b01, 0,  0,  14, 32'h90, 0,  0,  0,  1,  14, 32'h90, 1,  2};
    vecs[10] = '{1, 2'b00, 0,  14, 15, 32'hA0, 0,  1,  1,  0,  0,  32'h0,  2,  2};

    clear_d();
    rst_n = 1'b0;
    #2;
    chk("reset_e_bus", e_bus, '0);
    chk("reset_bubble_cnt", bubble_cnt, 0);
    chk("reset_flush_cnt", flush_cnt, 0);
    chk("reset_stall", {StallF, StallD, FlushD, FlushE}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      clear_d();
      RegWriteD = vecs[i].rw; ResultSrcD = vecs[i].rs;
      Rs1D = vecs[i].rs1; Rs2D = vecs[i].rs2; RdD = vecs[i].rd;
      RD1D = vecs[i].rd1; PCSrcE = vecs[i].pc;
      #1;
      chk($sformatf("v%0d_stallf", i), StallF, vecs[i].ex_stall);
      chk($sformatf("v%0d_stalld", i), StallD, vecs[i].ex_stall);
      chk($sformatf("v%0d_flushe", i), FlushE, vecs[i].ex_flushe);
      chk($sformatf("v%0d_flushd", i), FlushD, vecs[i].pc);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_regwritee", i), RegWriteE, vecs[i].ex_rw);
      chk($sformatf("v%0d_rde", i), RdE, vecs[i].ex_rd);
      chk($sformatf("v%0d_rd1e", i), RD1E, vecs[i].ex_rd1);
      chk($sformatf("v%0d_bubble_cnt", i), bubble_cnt, vecs[i].ex_bub);
      chk($sformatf("v%0d_flush_cnt", i), flush_cnt, vecs[i].ex_fl);
    end

    // Branch in D reaches E, then a taken branch clears it.
    @(negedge clk);
    clear_d();
    BranchD = 1; MemWriteD = 1; JumpD = 1; RdD = 5'd3;
    @(posedge clk); #1;
    chk("br_pass_branche", {BranchE, MemWriteE, JumpE}, 3'b111);
    @(negedge clk);
    PCSrcE = 1;
    #1;
    chk("br_flush_lines", {FlushD, FlushE, StallF, StallD}, 4'b1100);
    @(posedge clk); #1;
    chk("br_cleared", {BranchE, MemWriteE, JumpE, RegWriteE}, 4'b0000);
    chk("br_flush_cnt", flush_cnt, 3);

    // lw x7,0(x7) held in D: stalls on every other edge; counter must pin at 15.
    @(negedge clk);
    clear_d();
    RegWriteD = 1; ResultSrcD = 2'b01; Rs1D = 5'd7; RdD = 5'd7;
    stalls_seen = 0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (StallF) stalls_seen++;
      @(negedge clk);
    end
    chk("sat_stalls_seen", stalls_seen, 20);
    chk("sat_bubble_cnt", bubble_cnt, 15);
    chk("sat_flush_cnt", flush_cnt, 3);
    #1;
    chk("sat_no_stall_after_bubble", StallF, 0);
    @(posedge clk); #1;
    chk("sat_load_in_e", {ResultSrcE, RdE}, {2'b01, 5'd7});

    // Asynchronous reset mid-stream with a load in E.
    #2;
    rst_n = 1'b0;
    #1;
    chk("areset_e_bus", e_bus, '0);
    chk("areset_cnts", {bubble_cnt, flush_cnt}, 0);
    @(posedge clk); #1;
    chk("areset_held", e_bus, '0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("areset_released_before_edge", e_bus, '0);
    @(posedge clk); #1;
    chk("areset_first_edge_pass", e_bus, d_bus);

    // Spec passthrough of an ADD with every field distinct.
    @(negedge clk);
    clear_d();
    RegWriteD = 1; ALUSrcD = 1; ResultSrcD = 2'b10; ALUControlD = 5'b00000; mem_modeD = 3'b101;
    RD1D = 32'h11; RD2D = 32'h22; PCD = 32'h1000; ImmExtD = 32'hFFFF_FFF0; PCPlus4D = 32'h1004;
    Rs1D = 5'd1; Rs2D = 5'd2; RdD = 5'd5;
    #1;
    chk("add_no_hazard", {StallF, StallD, FlushD, FlushE}, 0);
    @(posedge clk); #1;
    chk("add_fields", e_bus, {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 5'b00000, 3'b101,
                              32'h11, 32'h22, 32'h1000, 32'hFFFF_FFF0, 32'h1004, 5'd1, 5'd2, 5'd5});
    chk("add_cnts", {bubble_cnt, flush_cnt}, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
